// File: rtl/arb_pkt_mux.sv
// Round-robin packet multiplexer: LENGTH request channels feed one registered output slot.
// Once a packet's first beat is granted, arbitration holds on that channel until its last beat.
module arb_pkt_mux #(
  parameter int LENGTH = 4,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LENGTH-1:0]        in_valid,
  input  logic [LENGTH*DATA_W-1:0] in_data,
  input  logic [LENGTH-1:0]        in_last,
  output logic [LENGTH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [LENGTH-1:0]        out_gnt,
  input  logic                     out_ready,
  output logic                     dbg_state,
  output logic [LENGTH-1:0]        dbg_ptr
);

  // Handshake rule, both sides: a beat moves on a rising edge where valid and ready are
  // both high; ready never depends on the same-cycle valid of another side's held beat
  // except through load_en (output slot empty or being drained this cycle).

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_e;

  localparam logic [LENGTH-1:0] ONE = {{(LENGTH-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [LENGTH-1:0]   ptr_q, ptr_d;
  logic [LENGTH-1:0]   lock_q, lock_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [LENGTH-1:0]   out_gnt_q, out_gnt_d;

  logic                load_en;
  logic [LENGTH-1:0]   masked;
  logic [LENGTH-1:0]   arb_grant;
  logic [LENGTH-1:0]   grant;
  logic                accept;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_last;

  // Requests at or above the pointer win first; otherwise wrap to the lowest requester.
  always_comb begin
    load_en   = !out_valid_q | out_ready;
    masked    = in_valid & ~(ptr_q - ONE);
    arb_grant = (|masked) ? (masked & (~masked + ONE)) : (in_valid & (~in_valid + ONE));
    grant     = (state_q == LOCK) ? (lock_q & in_valid) : arb_grant;
    accept    = load_en & !rst & (|grant);
    in_ready  = accept ? grant : '0;
    sel_data  = '0;
    sel_last  = 1'b0;
    for (int i = 0; i < LENGTH; i++) begin
      if (grant[i]) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
        sel_last = in_last[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_gnt_d   = out_gnt_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = sel_last;
      out_gnt_d   = grant;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ARB: begin
        if (accept && !sel_last) begin
          state_d = LOCK;
          lock_d  = grant;
        end
      end
      LOCK: begin
        if (accept && sel_last) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    if (accept && sel_last) begin
      ptr_d = {grant[LENGTH-2:0], grant[LENGTH-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= ONE;
      lock_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_gnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_gnt_q   <= out_gnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_gnt   = out_gnt_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_arb_pkt_mux.sv
// Directed bench for arb_pkt_mux: rotation, packet lock, backpressure, pointer wrap and
// mid-packet reset, with a beat-order scoreboard and an in_ready one-hot monitor.
module tb_arb_pkt_mux;

  localparam int LENGTH = 4;
  localparam int DATA_W = 8;

  logic                     clk;
  logic                     rst;
  logic [LENGTH-1:0]        in_valid;
  logic [LENGTH*DATA_W-1:0] in_data;
  logic [LENGTH-1:0]        in_last;
  logic [LENGTH-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [LENGTH-1:0]        out_gnt;
  logic                     out_ready;
  logic                     dbg_state;
  logic [LENGTH-1:0]        dbg_ptr;

  logic [DATA_W-1:0]        ch_data [LENGTH];
  logic [12:0]              exp_q[$];
  int                       n_checks;
  int                       n_pass;

  assign in_data = {ch_data[3], ch_data[2], ch_data[1], ch_data[0]};

  arb_pkt_mux #(.LENGTH(LENGTH), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_gnt   (out_gnt),
    .out_ready (out_ready),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // scoreboard: beats accepted at the inputs must leave in the same order, intact
  always @(negedge clk) begin
    chk("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
    if (rst) chk("in_ready_in_rst", 32'(in_ready), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        chk("sb_beat", 32'({out_gnt, out_last, out_data}), 32'(exp_q.pop_front()));
      end
    end
    for (int i = 0; i < LENGTH; i++) begin
      if (in_valid[i] && in_ready[i])
        exp_q.push_back({4'(1 << i), in_last[i], ch_data[i]});
    end
    if (rst) exp_q.delete();
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < LENGTH; i++) ch_data[i] = 8'(i * 16);
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_last   = 4'b1111;
    out_ready = 1'b0;

    // reset state
    cyc();
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_gnt", 32'(out_gnt), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_ptr", 32'(dbg_ptr), 32'h1);
    chk("rst_state", 32'(dbg_state), 32'h0);

    // test 1: fair rotation
    rst       = 1'b0;
    out_ready = 1'b1;
    settle();
    chk("t1_in_ready0", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t1_out_valid", 32'(out_valid), 32'h1);
      chk("t1_out_gnt", 32'(out_gnt), 32'(1 << (k % 4)));
      chk("t1_out_data", 32'(out_data), 32'((k % 4) * 16));
    end
    in_valid = 4'b0000;
    cyc();
    chk("t1_drained", 32'(out_valid), 32'h0);
    chk("t1_ptr", 32'(dbg_ptr), 32'h2);

    // test 2: packet lock on ch1 while ch0/ch2 request
    in_valid   = 4'b0111;
    in_last    = 4'b0101;
    ch_data[1] = 8'h11;
    settle();
    chk("t2_in_ready_b1", 32'(in_ready), 32'h2);
    cyc();
    chk("t2_b1_gnt", 32'(out_gnt), 32'h2);
    chk("t2_b1_data", 32'(out_data), 32'h11);
    chk("t2_b1_last", 32'(out_last), 32'h0);
    chk("t2_lock_state", 32'(dbg_state), 32'h1);
    in_valid = 4'b0101;
    settle();
    chk("t2_lock_ignores", 32'(in_ready), 32'h0);
    cyc();
    chk("t2_gap_out_valid", 32'(out_valid), 32'h0);
    in_valid   = 4'b0111;
    ch_data[1] = 8'h12;
    settle();
    chk("t2_in_ready_b2", 32'(in_ready), 32'h2);
    cyc();
    chk("t2_b2_data", 32'(out_data), 32'h12);
    chk("t2_b2_gnt", 32'(out_gnt), 32'h2);
    ch_data[1] = 8'h13;
    in_last    = 4'b0111;
    cyc();
    chk("t2_b3_data", 32'(out_data), 32'h13);
    chk("t2_b3_last", 32'(out_last), 32'h1);
    chk("t2_unlock_state", 32'(dbg_state), 32'h0);
    chk("t2_ptr_before_ch2", 32'(dbg_ptr), 32'h4);
    in_valid = 4'b0101;
    settle();
    chk("t2_in_ready_ch2", 32'(in_ready), 32'h4);
    cyc();
    chk("t2_ch2_gnt", 32'(out_gnt), 32'h4);
    chk("t2_ch2_data", 32'(out_data), 32'h20);
    in_valid = 4'b0000;
    cyc();
    chk("t2_ptr_after", 32'(dbg_ptr), 32'h8);

    // test 4: pointer at ch3, only ch0 requests -> wrap
    in_valid = 4'b0001;
    in_last  = 4'b1111;
    settle();
    chk("t4_in_ready", 32'(in_ready), 32'h1);
    cyc();
    chk("t4_gnt", 32'(out_gnt), 32'h1);
    chk("t4_ptr", 32'(dbg_ptr), 32'h2);
    in_valid = 4'b0000;
    cyc();

    // test 3: backpressure holds the beat
    out_ready  = 1'b0;
    in_valid   = 4'b0010;
    ch_data[1] = 8'hA5;
    settle();
    chk("t3_in_ready_load", 32'(in_ready), 32'h2);
    cyc();
    chk("t3_out_valid", 32'(out_valid), 32'h1);
    ch_data[1] = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("t3_stall_in_ready", 32'(in_ready), 32'h0);
      chk("t3_stall_data", 32'(out_data), 32'hA5);
      chk("t3_stall_valid", 32'(out_valid), 32'h1);
      chk("t3_stall_gnt", 32'(out_gnt), 32'h2);
      cyc();
    end
    out_ready = 1'b1;
    settle();
    chk("t3_release_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("t3_next_data", 32'(out_data), 32'h5A);
    in_valid = 4'b0000;
    cyc();
    chk("t3_drained", 32'(out_valid), 32'h0);

    // test 5: reset mid-packet on ch3 with a held beat
    in_valid   = 4'b1000;
    in_last    = 4'b0111;
    ch_data[3] = 8'h3C;
    settle();
    chk("t5_in_ready_ch3", 32'(in_ready), 32'h8);
    cyc();
    chk("t5_lock_state", 32'(dbg_state), 32'h1);
    chk("t5_gnt", 32'(out_gnt), 32'h8);
    out_ready = 1'b0;
    rst       = 1'b1;
    settle();
    chk("t5_rst_in_ready", 32'(in_ready), 32'h0);
    cyc();
    chk("t5_rst_out_valid", 32'(out_valid), 32'h0);
    chk("t5_rst_state", 32'(dbg_state), 32'h0);
    chk("t5_rst_ptr", 32'(dbg_ptr), 32'h1);
    rst       = 1'b0;
    out_ready = 1'b1;
    in_valid  = 4'b1001;
    in_last   = 4'b1111;
    settle();
    chk("t5_in_ready_ch0", 32'(in_ready), 32'h1);
    cyc();
    chk("t5_ch0_gnt", 32'(out_gnt), 32'h1);
    chk("t5_ch0_state", 32'(dbg_state), 32'h0);
    in_valid = 4'b0000;
    cyc();
    chk("t5_drained", 32'(out_valid), 32'h0);
    @(negedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
